uart_txq: RTL and testbench
===========================

Name: uart_txq

Overview:
- Transmit byte queue between the CPU-side write port and the UART transmitter (tx_vld/tx_data/txrdy interface).
- Buffers bytes written by software in a circular FIFO.
- Drains the FIFO into the transmitter as single-cycle tx_vld pulses, only when the transmitter reports ready.
- Exposes level, full, empty and sticky overflow status for polling.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries of 8 bits (16 by default).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  push wr_data this cycle
- wr_data  in  8  byte to queue
- ovf_clr  in  1  clears the sticky overflow flag
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- level  out  DEPTH_LOG2+1  current entry count, 0..DEPTH
- overflow  out  1  sticky: a write was dropped
- tx_vld  out  1  one-cycle launch strobe to transmitter
- tx_data  out  8  byte presented with tx_vld, registered
- txrdy  in  1  transmitter idle; goes low the cycle after it accepts tx_vld and stays low for the whole frame

Behaviour:
- Reset (async, rst=1) values: rd/wr pointers=0, level=0, empty=1, full=0, overflow=0, tx_vld=0, tx_data=8'h00, FSM=IDLE.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH. level is a separate counter.
- full = (level==DEPTH); empty = (level==0). Both are combinational from level.
- Push is accepted when wr_en & (~full | pop); a pop in the same cycle frees the slot, so a write while full with a concurrent pop is accepted and level is unchanged.
- Write rejected (wr_en & full & ~pop): data dropped, overflow <= 1.
- overflow clears on ovf_clr. If a set and a clear occur in the same cycle, set wins.
- FSM states:
  - IDLE: if ~empty & txrdy, pop head into tx_data, tx_vld <= 1 next cycle, go to SEND.
  - SEND: tx_vld=1 for exactly this cycle, go to BUSY.
  - BUSY: tx_vld=0; wait for txrdy==0, then go to DRAIN. If txrdy is still 1 after 2 cycles in BUSY, return to IDLE anyway; this guards against a lost strobe.
  - DRAIN: wait for txrdy==1, then go to IDLE.
- pop is asserted only on the IDLE->SEND transition. Latency from write into an empty FIFO with txrdy=1 to tx_vld is 2 cycles (write cycle, pop cycle, then tx_vld high).
- Back-to-back bytes: the next launch occurs no earlier than 1 cycle after txrdy returns high. tx_vld is never asserted on two consecutive cycles.
- tx_data holds its value outside SEND.
- Reset mid-frame: queue contents are discarded and the FSM returns to IDLE. Transmitter reset is handled by the transmitter itself.
- wr_en while rst=1 is ignored.

Optional Feature:
- Macro UART_TXQ_CRLF_EN.
- When defined: a popped byte equal to 8'h0A is preceded by an automatic 8'h0D. The FSM sends 0x0D through SEND/BUSY/DRAIN first, then sends 0x0A without popping again; the LF is held in a 1-bit pending flag plus the head entry. level counts only software-written bytes.
- When undefined: bytes are sent verbatim, and the pending-flag logic is absent.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, SEND, BUSY, DRAIN)
  - byte constants CHAR_CR=8'h0D and CHAR_LF=8'h0A
  - BUSY timeout constant of 2
- Sub-module uart_fifo_sync: generic single-clock FIFO with parameter DEPTH_LOG2, ports push/pop/din/dout/level/full/empty.
- uart_txq instantiates uart_fifo_sync and contains the FSM, overflow logic and CRLF logic.

Test Plan:
- Reset then idle with txrdy=1 -> empty=1, level=0, tx_vld stays 0 for 100 cycles.
- Write 8'h55 with txrdy=1 -> tx_vld pulses once, 2 cycles after the write, with tx_data=8'h55. Model txrdy low for 10 bit periods; no second pulse occurs.
- Write 16 bytes 0x00..0x0F with txrdy held 0 -> full=1, level=16. A 17th write 0xAA sets overflow=1 and is dropped. Release txrdy -> 16 bytes sent in order 0x00..0x0F; wrap-around verified with a second burst of 20 bytes.
- With full=1, write in the same cycle as the IDLE pop -> write accepted, level stays 16, the byte appears in order.
- ovf_clr asserted in the same cycle as a dropped write -> overflow remains 1. ovf_clr alone -> overflow returns to 0.
- CRLF_EN defined: write 8'h41, 8'h0A -> tx_data sequence 0x41, 0x0D, 0x0A. Undefined: 0x41, 0x0A. Also pulse rst mid-sequence -> tx_vld=0 and empty=1 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: FSM encoding, byte constants and BUSY timeout shared by the transmit queue
package uart_pkg;
    typedef logic [1:0] txq_state_t;
    localparam txq_state_t ST_IDLE  = 2'd0;
    localparam txq_state_t ST_SEND  = 2'd1;
    localparam txq_state_t ST_BUSY  = 2'd2;
    localparam txq_state_t ST_DRAIN = 2'd3;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam int BUSY_TIMEOUT = 2;
    localparam int BUSY_CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
endpackage

// File: rtl/uart_txq_if.sv
// uart_txq_if: CPU write port, status and transmitter handshake of the transmit queue
interface uart_txq_if #(parameter int DEPTH_LOG2 = 4);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  ovf_clr;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  tx_vld;
    logic [7:0]            tx_data;
    logic                  txrdy;
    modport master (output wr_en, wr_data, ovf_clr, txrdy,
                    input  full, empty, level, overflow, tx_vld, tx_data);
    modport slave  (input  wr_en, wr_data, ovf_clr, txrdy,
                    output full, empty, level, overflow, tx_vld, tx_data);
endinterface

// File: rtl/uart_fifo_sync.sv
// uart_fifo_sync: single-clock circular byte FIFO; a pop frees a slot for a same-cycle push
module uart_fifo_sync #(parameter int DEPTH_LOG2 = 4) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [7:0]          din,
    output logic [7:0]          dout,
    output logic [DEPTH_LOG2:0] level,
    output logic                full,
    output logic                empty
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic                  do_push, do_pop;
    assign full    = level == (DEPTH_LOG2+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
endmodule

// File: rtl/uart_txq.sv
// uart_txq: transmit byte queue feeding a UART as single-cycle tx_vld strobes
// UART_TXQ_CRLF_EN: insert an automatic CR in front of every LF popped from the queue
module uart_txq import uart_pkg::*; #(parameter int DEPTH_LOG2 = 4) (
    input logic        clk,
    input logic        rst,
    uart_txq_if.slave  bus
);
    txq_state_t            state, state_nx;
    logic [BUSY_CNT_W-1:0] busy_cnt;
    logic [DEPTH_LOG2:0]   level;
    logic [7:0]            head, launch_byte, tx_data;
    logic                  full, empty, launch, pop, busy_to, overflow, tx_vld;
    uart_fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wr_en),
        .pop   (pop),
        .din   (bus.wr_data),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );
    assign launch  = (state == ST_IDLE) & ~empty & bus.txrdy;
    assign busy_to = busy_cnt == BUSY_CNT_W'(BUSY_TIMEOUT - 1);
`ifdef UART_TXQ_CRLF_EN
    logic lf_pend, cr_first;
    // LF stays at the head until its CR has gone out, so no extra storage is needed
    assign cr_first    = (head == CHAR_LF) & ~lf_pend;
    assign pop         = launch & ~cr_first;
    assign launch_byte = cr_first ? CHAR_CR : head;
    always_ff @(posedge clk or posedge rst)
        if (rst) lf_pend <= 1'b0;
        else if (launch) lf_pend <= cr_first;
`else
    assign pop         = launch;
    assign launch_byte = head;
`endif
    always_comb
        state_nx = (state == ST_IDLE) ? (launch ? ST_SEND : ST_IDLE) :
                   (state == ST_SEND) ? ST_BUSY :
                   (state == ST_BUSY) ? (~bus.txrdy ? ST_DRAIN : busy_to ? ST_IDLE : ST_BUSY) :
                   (bus.txrdy ? ST_IDLE : ST_DRAIN);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= ST_IDLE;
            busy_cnt <= '0;
            tx_vld   <= 1'b0;
            tx_data  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            busy_cnt <= (state == ST_BUSY) ? busy_cnt + 1'b1 : '0;
            tx_vld   <= launch;
            if (launch) tx_data <= launch_byte;
            if (bus.wr_en & full & ~pop) overflow <= 1'b1;
            else if (bus.ovf_clr) overflow <= 1'b0;
        end
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level;
    assign bus.overflow = overflow;
    assign bus.tx_vld   = tx_vld;
    assign bus.tx_data  = tx_data;
endmodule

// File: tb/tb_uart_txq.sv
// tb_uart_txq: directed vector bench for uart_txq with a simple transmitter model
module tb_uart_txq;
    localparam int DL = 4;
    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       clr;
        logic [4:0] lvl;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hold = 1'b0;
    logic       ignore = 1'b0;
    logic [3:0] frm = 4'd0;
    logic       prev_vld = 1'b0;
    logic       dbl_seen = 1'b0;
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] cap [$];
    int         cap_t [$];
    vec_t       tbl [20];
    uart_txq_if #(.DEPTH_LOG2(DL)) bus ();
    uart_txq #(.DEPTH_LOG2(DL)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // transmitter model: txrdy drops the cycle after a strobe and stays low for 10 bit periods
    assign bus.txrdy = ~hold & (frm == 4'd0);
    always @(posedge clk or posedge rst)
        if (rst) frm <= 4'd0;
        else if (bus.tx_vld & ~ignore) frm <= 4'd10;
        else if (frm != 4'd0) frm <= frm - 4'd1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.tx_vld) begin
            cap.push_back(bus.tx_data);
            cap_t.push_back(cyc);
        end
        if (bus.tx_vld & prev_vld) dbl_seen <= 1'b1;
        prev_vld <= bus.tx_vld;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_data = d;
        step(1);
        bus.wr_en = 1'b0;
    endtask
    task automatic wait_caps(input string name, input int n, input int bound);
        for (int k = 0; k < bound && cap.size() < n; k++) step(1);
        check(name, 32'(cap.size() >= n), 32'd1);
    endtask
    function automatic logic [31:0] cap_at(input int i);
        return (i < cap.size()) ? 32'(cap[i]) : 32'hDEAD;
    endfunction
    initial begin
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 8'(i), 1'b0, 5'(i + 1), 1'(i == 15), 1'b0, 1'b0};
        tbl[16] = '{1'b1, 8'hAA, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 8'hAA, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};
        bus.ovf_clr = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h99;
        step(3);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_tx_vld", 32'(bus.tx_vld), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        bus.wr_en = 1'b0;
        rst = 1'b0;
        step(100);
        check("idle_no_pulse", 32'(cap.size()), 32'd0);
        check("idle_empty", 32'(bus.empty), 32'd1);
        check("idle_level", 32'(bus.level), 32'd0);
        wr(8'h55);
        check("single_level", 32'(bus.level), 32'd1);
        check("single_vld_cyc1", 32'(bus.tx_vld), 32'd0);
        step(1);
        check("single_vld_cyc2", 32'(bus.tx_vld), 32'd1);
        check("single_data", 32'(bus.tx_data), 32'h55);
        step(1);
        check("single_vld_drop", 32'(bus.tx_vld), 32'd0);
        step(20);
        check("single_count", 32'(cap.size()), 32'd1);
        check("single_cap", cap_at(0), 32'h55);
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.wr_en = tbl[i].wr;
            bus.wr_data = tbl[i].d;
            bus.ovf_clr = tbl[i].clr;
            step(1);
            check($sformatf("tbl%0d_level", i), 32'(bus.level), 32'(tbl[i].lvl));
            check($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].full));
            check($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].empty));
            check($sformatf("tbl%0d_ovf", i), 32'(bus.overflow), 32'(tbl[i].ovf));
        end
        bus.wr_en = 1'b0;
        bus.ovf_clr = 1'b0;
        cap.delete();
        hold = 1'b0;
        wait_caps("burst1_done", 16, 500);
        for (int i = 0; i < 16; i++) check($sformatf("burst1_%0d", i), cap_at(i), 32'(i));
        step(20);
        check("burst1_empty", 32'(bus.empty), 32'd1);
        hold = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
        check("burst2_full", 32'(bus.full), 32'd1);
        cap.delete();
        hold = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h20;
        step(1);
        bus.wr_en = 1'b0;
        check("concur_level", 32'(bus.level), 32'd16);
        check("concur_full", 32'(bus.full), 32'd1);
        check("concur_ovf", 32'(bus.overflow), 32'd0);
        wait_caps("burst2_partial", 4, 200);
        for (int i = 1; i < 4; i++) wr(8'(8'h20 + i));
        wait_caps("burst2_done", 20, 600);
        for (int i = 0; i < 20; i++) check($sformatf("burst2_%0d", i), cap_at(i), 32'(8'h10 + i));
        check("burst2_ovf", 32'(bus.overflow), 32'd0);
        step(20);
        ignore = 1'b1;
        cap.delete();
        cap_t.delete();
        wr(8'h61);
        wr(8'h62);
        wait_caps("timeout_done", 2, 50);
        check("timeout_gap", (cap_t.size() >= 2) ? 32'(cap_t[1] - cap_t[0]) : 32'hDEAD, 32'd4);
        check("timeout_b1", cap_at(1), 32'h62);
        ignore = 1'b0;
        step(20);
        cap.delete();
        wr(8'h41);
        wr(8'h0A);
`ifdef UART_TXQ_CRLF_EN
        wait_caps("crlf_done", 3, 200);
        step(30);
        check("crlf_count", 32'(cap.size()), 32'd3);
        check("crlf_0", cap_at(0), 32'h41);
        check("crlf_1", cap_at(1), 32'h0D);
        check("crlf_2", cap_at(2), 32'h0A);
`else
        wait_caps("crlf_done", 2, 200);
        step(30);
        check("crlf_count", 32'(cap.size()), 32'd2);
        check("crlf_0", cap_at(0), 32'h41);
        check("crlf_1", cap_at(1), 32'h0A);
`endif
        check("crlf_empty", 32'(bus.empty), 32'd1);
        cap.delete();
        wr(8'h31);
        wr(8'h32);
        wr(8'h33);
        for (int k = 0; k < 20 && !bus.tx_vld; k++) step(1);
        check("midrst_launch", 32'(bus.tx_vld), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_vld", 32'(bus.tx_vld), 32'd0);
        check("midrst_empty", 32'(bus.empty), 32'd1);
        check("midrst_level", 32'(bus.level), 32'd0);
        step(2);
        rst = 1'b0;
        begin
            int n0;
            n0 = cap.size();
            step(40);
            check("midrst_no_resend", 32'(cap.size()), 32'(n0));
        end
        check("no_back_to_back", 32'(dbl_seen), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
